// File: rtl/lsu_master.sv
// Load/store unit master: turns one CPU load/store request into word-wide memory
// accesses. Sub-word stores use a read-modify-write pair. Misaligned accesses and
// memory-ack timeouts are reported through exc together with the done pulse.
module lsu_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned ADDR_W  = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              req,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rdata,
  output logic [1:0]        exc,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [1:0] {StIdle, StRd, StWr, StDone} state_e;

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSb  = 3'b111;

  localparam logic [1:0] ExcNone  = 2'b00;
  localparam logic [1:0] ExcAlign = 2'b01;
  localparam logic [1:0] ExcTmo   = 2'b10;

  // Counter value on the last unacknowledged cycle before giving up.
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [15:0]         wd_q, wd_d;
  logic [15:0]         cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         rdata_q, rdata_d;
  logic [1:0]          exc_q, exc_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic                misaligned;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;
  logic [31:0]         load_val;
  logic [31:0]         merged;

  // Lane selection, load extension and store merge from the latched access.
  always_comb begin
    lane_h = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (addr_lo_q)
      2'd0:    lane_b = mem_rdata[7:0];
      2'd1:    lane_b = mem_rdata[15:8];
      2'd2:    lane_b = mem_rdata[23:16];
      default: lane_b = mem_rdata[31:24];
    endcase
    case (op_q)
      OpLh:    load_val = {{16{lane_h[15]}}, lane_h};
      OpLhu:   load_val = {16'h0000, lane_h};
      OpLb:    load_val = {{24{lane_b[7]}}, lane_b};
      OpLbu:   load_val = {24'h000000, lane_b};
      default: load_val = mem_rdata;
    endcase
    merged = mem_rdata;
    if (op_q == OpSh) begin
      if (addr_lo_q[1]) merged[31:16] = wd_q;
      else              merged[15:0]  = wd_q;
    end else begin
      unique case (addr_lo_q)
        2'd0:    merged[7:0]   = wd_q[7:0];
        2'd1:    merged[15:8]  = wd_q[7:0];
        2'd2:    merged[23:16] = wd_q[7:0];
        default: merged[31:24] = wd_q[7:0];
      endcase
    end
  end

  // Alignment check on the incoming request.
  always_comb begin
    case (op)
      OpLw, OpSw:        misaligned = (addr[1:0] != 2'b00);
      OpLh, OpLhu, OpSh: misaligned = addr[0];
      default:           misaligned = 1'b0;
    endcase
  end

  // Next-state logic for the FSM and every registered output.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    wd_d        = wd_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    exc_d       = exc_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      StIdle: begin
        if (req) begin
          op_d      = op;
          addr_lo_d = addr[1:0];
          wd_d      = wdata[15:0];
          if (misaligned) begin
            state_d = StDone;
            exc_d   = ExcAlign;
          end else begin
            mem_addr_d = {addr[ADDR_W-1:2], 2'b00};
            cnt_d      = 16'd0;
            mem_req_d  = 1'b1;
            if (op == OpSw) begin
              state_d     = StWr;
              mem_we_d    = 1'b1;
              mem_wdata_d = wdata;
            end else begin
              state_d  = StRd;
              mem_we_d = 1'b0;
            end
          end
        end
      end
      StRd, StWr: begin
        if (mem_ack) begin
          if (state_q == StRd && (op_q == OpSh || op_q == OpSb)) begin
            // Read half of read-modify-write: keep mem_req up and turn it into a write.
            state_d     = StWr;
            mem_we_d    = 1'b1;
            mem_wdata_d = merged;
            cnt_d       = 16'd0;
          end else begin
            if (state_q == StRd) rdata_d = load_val;
            state_d   = StDone;
            exc_d     = ExcNone;
            mem_req_d = 1'b0;
            mem_we_d  = 1'b0;
          end
        end else if (cnt_q == TmoLast) begin
          state_d   = StDone;
          exc_d     = ExcTmo;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_d == StDone);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q     <= StIdle;
      op_q        <= 3'b000;
      addr_lo_q   <= 2'b00;
      wd_q        <= 16'h0000;
      cnt_q       <= 16'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rdata_q     <= 32'h0;
      exc_q       <= 2'b00;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_lo_q   <= addr_lo_d;
      wd_q        <= wd_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign exc       = exc_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_master.sv
// Scoreboard bench for lsu_master: a driver issues loads/stores and queues the
// expected results and memory accesses; a memory responder and a done monitor
// pop and compare independently.
module tb_lsu_master;

  localparam int unsigned TMO = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        req;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] rdata;
  logic [1:0]  exc;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  always #5 CLK = ~CLK;

  lsu_master #(.TIMEOUT(TMO), .ADDR_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .exc(exc),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  typedef struct {logic we; logic [31:0] addr; logic [31:0] data;} acc_t;
  typedef struct {logic [31:0] rdata; logic [1:0] exc;} res_t;

  acc_t        acc_q[$];
  res_t        res_q[$];
  logic [31:0] mem     [0:255];
  logic [31:0] ref_mem [0:255];
  logic [31:0] exp_rdata = 32'h0;
  bit          stall = 1'b0;
  bit          fast_ack = 1'b1;
  int          n_tests = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Memory responder: acks requests (bounded random wait), checks accesses.
  initial begin
    int   wait_n;
    acc_t e;
    wait_n = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(negedge CLK);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!Reset) begin
        wait_n = 0;
      end else if (mem_req && !stall) begin
        if (acc_q.size() == 0) begin
          chk("mem_req_unexpected", {31'd0, mem_req}, 32'd0);
        end else if (fast_ack || wait_n >= 2 || $urandom_range(1, 0) == 1) begin
          e = acc_q.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, e.we});
          chk("mem_addr", mem_addr, e.addr);
          if (e.we) begin
            chk("mem_wdata", mem_wdata, e.data);
            mem[mem_addr[9:2]] = mem_wdata;
          end else begin
            mem_rdata = mem[mem_addr[9:2]];
          end
          mem_ack = 1'b1;
          wait_n = 0;
        end else begin
          wait_n++;
        end
      end else if (!mem_req) begin
        wait_n = 0;
        mem_ack = 1'($urandom_range(1, 0));
      end
    end
  end

  // Done monitor: every done pulse must match the oldest queued result.
  initial begin
    res_t r;
    forever begin
      @(negedge CLK);
      if (Reset && done) begin
        if (res_q.size() == 0) begin
          chk("done_unexpected", {31'd0, done}, 32'd0);
        end else begin
          r = res_q.pop_front();
          chk("rdata", rdata, r.rdata);
          chk("exc", {30'd0, exc}, {30'd0, r.exc});
        end
      end
    end
  end

  // Issue one access, queue its expectations from the reference model, wait for done.
  task automatic run_txn(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd,
                         input bit stl);
    int          size, lane, n, reqcnt, exp_lat;
    bit          mis, seen;
    logic [31:0] word, ld, mask, nw, wa;
    res_t        r;
    acc_t        e;
    size = (o == 3'd0 || o == 3'd5) ? 4 : ((o == 3'd1 || o == 3'd2 || o == 3'd6) ? 2 : 1);
    mis  = (a % size) != 0;
    wa   = a & 32'hFFFF_FFFC;
    word = ref_mem[a[9:2]];
    lane = int'(a[1:0]) * 8;
    if (mis) begin
      r.rdata = exp_rdata; r.exc = 2'b01; res_q.push_back(r);
    end else if (stl) begin
      r.rdata = exp_rdata; r.exc = 2'b10; res_q.push_back(r);
    end else if (o <= 3'd4) begin
      ld = word >> lane;
      case (o)
        3'd1:    ld = {{16{ld[15]}}, ld[15:0]};
        3'd2:    ld = {16'h0, ld[15:0]};
        3'd3:    ld = {{24{ld[7]}}, ld[7:0]};
        3'd4:    ld = {24'h0, ld[7:0]};
        default: ld = word;
      endcase
      exp_rdata = ld;
      r.rdata = ld; r.exc = 2'b00; res_q.push_back(r);
      e.we = 1'b0; e.addr = wa; e.data = 32'h0; acc_q.push_back(e);
    end else begin
      mask = (o == 3'd6) ? 32'h0000_FFFF : 32'h0000_00FF;
      if (o == 3'd5) nw = wd;
      else nw = (word & ~(mask << lane)) | ((wd & mask) << lane);
      if (o != 3'd5) begin
        e.we = 1'b0; e.addr = wa; e.data = 32'h0; acc_q.push_back(e);
      end
      e.we = 1'b1; e.addr = wa; e.data = nw; acc_q.push_back(e);
      ref_mem[a[9:2]] = nw;
      r.rdata = exp_rdata; r.exc = 2'b00; res_q.push_back(r);
    end
    @(negedge CLK);
    stall = stl;
    op = o; addr = a; wdata = wd; req = 1'b1;
    n = 0; reqcnt = 0; seen = 1'b0;
    while (n < 200) begin
      @(negedge CLK);
      n++;
      if (mem_req) reqcnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      // Changes while busy must have no effect.
      op = 3'($urandom); addr = $urandom; wdata = $urandom;
    end
    req = 1'b0;
    stall = 1'b0;
    chk("done_seen", {31'd0, seen}, 32'd1);
    exp_lat = mis ? 1 : (stl ? int'(TMO) + 1 : ((o == 3'd6 || o == 3'd7) ? 3 : 2));
    if (fast_ack || mis || stl) chk("latency", 32'(n), 32'(exp_lat));
    if (mis) chk("req_cycles_misaligned", 32'(reqcnt), 32'd0);
    else if (stl) chk("req_cycles_timeout", 32'(reqcnt), 32'(TMO));
  endtask

  initial begin
    Reset = 1'b0; req = 1'b0; op = 3'd0; addr = 32'h0; wdata = 32'h0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    repeat (3) @(negedge CLK);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_exc", {30'd0, exc}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    Reset = 1'b1;

    // Directed cases with immediate acks.
    mem[64] = 32'h80FF1234; ref_mem[64] = 32'h80FF1234;
    run_txn(3'd3, 32'h103, 32'h0, 1'b0);
    chk("lb_0x103", rdata, 32'hFFFFFF80);
    mem[8] = 32'hBEEF0000; ref_mem[8] = 32'hBEEF0000;
    run_txn(3'd2, 32'h22, 32'h0, 1'b0);
    chk("lhu_0x22", rdata, 32'h0000BEEF);
    run_txn(3'd1, 32'h22, 32'h0, 1'b0);
    chk("lh_0x22", rdata, 32'hFFFFBEEF);
    mem[16] = 32'h11223344; ref_mem[16] = 32'h11223344;
    run_txn(3'd7, 32'h41, 32'hAA, 1'b0);
    chk("sb_0x41_mem", mem[16], 32'h1122AA44);
    chk("sb_keeps_rdata", rdata, 32'hFFFFBEEF);
    run_txn(3'd5, 32'h06, 32'h12345678, 1'b0);
    run_txn(3'd0, 32'h10, 32'h0, 1'b0);
    run_txn(3'd5, 32'h14, 32'hCAFEF00D, 1'b0);
    run_txn(3'd6, 32'h1A, 32'h5555_9876, 1'b0);
    run_txn(3'd1, 32'h33, 32'h0, 1'b0);
    run_txn(3'd0, 32'h24, 32'h0, 1'b1);
    run_txn(3'd6, 32'h24, 32'h1111, 1'b1);

    // Reset in the middle of a stalled load: aborts with no done pulse.
    @(negedge CLK);
    stall = 1'b1; op = 3'd0; addr = 32'h20; req = 1'b1;
    repeat (2) @(negedge CLK);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_mem_req", {31'd0, mem_req}, 32'd1);
    Reset = 1'b0;
    #1;
    chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    exp_rdata = 32'h0;
    req = 1'b0; stall = 1'b0;
    @(negedge CLK);
    Reset = 1'b1;
    run_txn(3'd0, 32'h20, 32'h0, 1'b0);

    // Random traffic with random ack delays and occasional stalls.
    fast_ack = 1'b0;
    for (int i = 0; i < 150; i++) begin
      run_txn(3'($urandom), {22'd0, 10'($urandom)}, $urandom, ($urandom_range(7, 0) == 0));
      repeat ($urandom_range(2, 0)) @(negedge CLK);
    end

    repeat (5) @(negedge CLK);
    chk("res_q_drained", 32'(res_q.size()), 32'd0);
    chk("acc_q_drained", 32'(acc_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
